// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer built from a prescaler and a
// period down-counter, with one-shot/periodic modes, pause, restart and abort.
module timer_ctrl #(
  parameter int unsigned CLK_DIV = 25000,
  parameter int unsigned WIDTH   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_periodic,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tick,
  output logic             o_expire,
  output logic             o_err,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             expire_d, err_d;
  logic             active_c;
  logic             start_ok_c;

  // Timebase advances whenever a live timer sees pause low; releasing a pause
  // is effective on the same edge, so the delay equals the cycles held paused.
  assign active_c   = ((state_q == S_RUNNING) || (state_q == S_PAUSED)) && !i_pause;
  assign start_ok_c = i_start && (i_period != '0);

  assign o_tick  = active_c && (pre_q == PRE_MAX);
  assign o_count = count_q;
  assign o_state = state_q;
  assign o_busy  = (state_q == S_RUNNING) || (state_q == S_PAUSED);

  // State, counters and output pulse registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      o_expire   <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      count_q    <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      o_expire   <= expire_d;
      o_err      <= err_d;
    end
  end

  // Next-state: stop > accepted start > pause > tick
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    count_d    = count_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    expire_d   = 1'b0;
    err_d      = 1'b0;

    if (i_stop) begin
      state_d = S_IDLE;
      count_d = '0;
      pre_d   = '0;
    end else if (start_ok_c) begin
      period_d   = i_period;
      periodic_d = i_periodic;
      count_d    = i_period;
      pre_d      = '0;
      state_d    = S_RUNNING;
    end else begin
      // A zero-period start is flagged and otherwise ignored
      err_d = i_start;
      case (state_q)
        S_RUNNING, S_PAUSED: begin
          if (i_pause) begin
            state_d = S_PAUSED;
          end else begin
            state_d = S_RUNNING;
            if (pre_q == PRE_MAX) begin
              pre_d = '0;
              if (count_q > COUNT_ONE) begin
                count_d = count_q - COUNT_ONE;
              end else begin
                expire_d = 1'b1;
                if (periodic_q) begin
                  count_d = period_q;
                end else begin
                  count_d = '0;
                  state_d = S_DONE;
                end
              end
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end
        default: pre_d = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the timer.
module tb_timer_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned WIDTH   = 8;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic             i_pause = 1'b0;
  logic             i_periodic = 1'b0;
  logic [WIDTH-1:0] i_period = '0;
  logic [WIDTH-1:0] o_count;
  logic             o_tick, o_expire, o_err, o_busy;
  logic [1:0]       o_state;

  int checks = 0;
  int failures = 0;

  // Behavioural model: plain integers, updated once per rising edge
  int m_state = 0;   // 0 idle, 1 running, 2 paused, 3 done
  int m_count = 0;
  int m_pre = 0;     // cycles elapsed in the current tick
  int m_period = 0;
  int m_periodic = 0;
  int m_expire = 0;
  int m_err = 0;

  timer_ctrl #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_pause(i_pause), .i_periodic(i_periodic), .i_period(i_period),
    .o_count(o_count), .o_tick(o_tick), .o_expire(o_expire), .o_err(o_err),
    .o_busy(o_busy), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic void model_reset();
    m_state = 0; m_count = 0; m_pre = 0; m_period = 0; m_periodic = 0;
    m_expire = 0; m_err = 0;
  endfunction

  function automatic void model_edge(input bit start, input bit stop, input bit pause,
                                     input bit periodic, input int period);
    m_expire = 0;
    m_err = 0;
    if (stop) begin
      m_state = 0; m_count = 0; m_pre = 0;
    end else if (start && period != 0) begin
      m_period = period; m_periodic = periodic; m_count = period; m_pre = 0; m_state = 1;
    end else begin
      if (start) m_err = 1;
      if (m_state == 1 || m_state == 2) begin
        if (pause) m_state = 2;
        else begin
          m_state = 1;
          m_pre = m_pre + 1;
          if (m_pre == CLK_DIV) begin
            m_pre = 0;
            m_count = m_count - 1;
            if (m_count == 0) begin
              m_expire = 1;
              if (m_periodic != 0) m_count = m_period;
              else m_state = 3;
            end
          end
        end
      end else m_pre = 0;
    end
  endfunction

  function automatic bit model_tick();
    return (m_state == 1 || m_state == 2) && !i_pause && (m_pre == CLK_DIV - 1);
  endfunction

  // One rising edge: model follows the inputs sampled at that edge; strobes drop
  task automatic cycle();
    @(posedge i_clk);
    if (!i_reset) model_edge(i_start, i_stop, i_pause, i_periodic, int'(i_period));
    #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic launch(input int period, input bit periodic);
    i_start = 1'b1; i_period = WIDTH'(period); i_periodic = periodic;
    cycle();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (o_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    checks++; if ({o_expire, o_err, o_busy, o_tick} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {o_expire, o_err, o_busy, o_tick});
    end
    @(negedge i_clk); i_reset = 1'b0;
    @(posedge i_clk); #1;
    model_reset();
  endtask

  task automatic test_oneshot();
    int exp_count;
    launch(3, 1'b0);
    for (int e = 1; e <= 14; e++) begin
      cycle();
      exp_count = (e >= 12) ? 0 : 3 - e / 4;
      checks++; if (o_count !== WIDTH'(exp_count)) begin
        failures++; $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", e, o_count, exp_count);
      end
      checks++; if (o_expire !== (e == 12)) begin
        failures++; $display("FAIL oneshot_expire edge=%0d got=%b exp=%b", e, o_expire, e == 12);
      end
      checks++; if (o_state !== ((e >= 12) ? 2'd3 : 2'd1) || o_busy !== (e < 12)) begin
        failures++; $display("FAIL oneshot_state edge=%0d state=%0d busy=%b", e, o_state, o_busy);
      end
    end
  endtask

  task automatic test_periodic();
    launch(2, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      cycle();
      checks++; if (o_expire !== (e == 8 || e == 16)) begin
        failures++; $display("FAIL periodic_expire edge=%0d got=%b", e, o_expire);
      end
      checks++; if (o_count !== WIDTH'(((e % 8) < 4) ? 2 : 1) || o_state !== 2'd1) begin
        failures++; $display("FAIL periodic_count edge=%0d count=%0d state=%0d", e, o_count, o_state);
      end
    end
    i_stop = 1'b1; cycle();
    checks++; if (o_state !== 2'd0 || o_count !== '0) begin
      failures++; $display("FAIL periodic_stop state=%0d count=%0d exp=0/0", o_state, o_count);
    end
  endtask

  task automatic test_pause();
    launch(3, 1'b1);
    for (int e = 1; e <= 18; e++) begin
      i_pause = (e >= 6 && e <= 10);
      cycle();
      checks++; if (o_expire !== (e == 17)) begin
        failures++; $display("FAIL pause_expire edge=%0d got=%b exp=%b", e, o_expire, e == 17);
      end
      if (e >= 6 && e <= 10) begin
        checks++; if (o_state !== 2'd2 || o_count !== WIDTH'(2) || o_busy !== 1'b1) begin
          failures++; $display("FAIL pause_hold edge=%0d state=%0d count=%0d", e, o_state, o_count);
        end
      end
      if (e == 11) begin
        checks++; if (o_state !== 2'd1) begin
          failures++; $display("FAIL pause_resume got=%0d exp=1", o_state);
        end
      end
    end
    i_pause = 1'b0;
    i_stop = 1'b1; cycle();
  endtask

  task automatic test_err();
    i_start = 1'b1; i_period = '0; cycle();
    checks++; if (o_err !== 1'b1 || o_state !== 2'd0) begin
      failures++; $display("FAIL err_idle err=%b state=%0d exp=1/0", o_err, o_state);
    end
    cycle();
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", o_err); end
    launch(3, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      if (e == 2) begin i_start = 1'b1; i_period = '0; end
      cycle();
      if (e == 2) begin
        checks++; if (o_err !== 1'b1 || o_count !== WIDTH'(3) || o_state !== 2'd1) begin
          failures++; $display("FAIL err_running err=%b count=%0d state=%0d", o_err, o_count, o_state);
        end
      end
      checks++; if (o_expire !== (e == 12)) begin
        failures++; $display("FAIL err_expire edge=%0d got=%b", e, o_expire);
      end
    end
  endtask

  task automatic test_stop_cases();
    launch(3, 1'b0);
    cycle();
    i_start = 1'b1; i_stop = 1'b1; i_period = WIDTH'(5); cycle();
    checks++; if (o_state !== 2'd0 || o_count !== '0) begin
      failures++; $display("FAIL start_stop state=%0d count=%0d exp=0/0", o_state, o_count);
    end
    launch(1, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      i_stop = (e == 4);
      cycle();
      checks++; if (o_expire !== 1'b0) begin
        failures++; $display("FAIL stop_final_tick edge=%0d got=%b exp=0", e, o_expire);
      end
    end
    checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL stop_final_state got=%0d exp=0", o_state); end
    launch(2, 1'b1);
    for (int e = 1; e <= 19; e++) begin
      if (e == 6) begin i_start = 1'b1; i_period = WIDTH'(3); i_periodic = 1'b0; end
      cycle();
      if (e == 6) begin
        checks++; if (o_count !== WIDTH'(3)) begin failures++; $display("FAIL restart_count got=%0d exp=3", o_count); end
      end
      checks++; if (o_expire !== (e == 18)) begin
        failures++; $display("FAIL restart_expire edge=%0d got=%b", e, o_expire);
      end
    end
  endtask

  task automatic test_async_reset();
    launch(5, 1'b1);
    repeat (6) cycle();
    #3 i_reset = 1'b1;
    #1;
    checks++; if (o_count !== '0 || o_state !== 2'd0 || o_busy !== 1'b0 || o_tick !== 1'b0
                  || o_expire !== 1'b0 || o_err !== 1'b0) begin
      failures++; $display("FAIL async_reset count=%0d state=%0d busy=%b", o_count, o_state, o_busy);
    end
    @(posedge i_clk); #2;
    i_reset = 1'b0;
    model_reset();
    for (int e = 0; e < 8; e++) begin
      cycle();
      checks++; if (o_state !== 2'd0 || o_count !== '0) begin
        failures++; $display("FAIL post_reset_idle cyc=%0d state=%0d count=%0d", e, o_state, o_count);
      end
    end
  endtask

  task automatic test_random();
    int p;
    for (int n = 0; n < 600; n++) begin
      i_stop  = ($urandom_range(39) == 0);
      i_start = ($urandom_range(14) == 0);
      p = ($urandom_range(19) == 0) ? 255 : int'($urandom_range(5));
      i_period = WIDTH'(p);
      i_periodic = $urandom_range(1);
      if ($urandom_range(7) == 0) i_pause = ~i_pause;
      #1;
      checks++; if (o_tick !== model_tick()) begin
        failures++; $display("FAIL rand_tick n=%0d got=%b exp=%b", n, o_tick, model_tick());
      end
      cycle();
      checks++; if (o_count !== WIDTH'(m_count) || o_state !== 2'(m_state)) begin
        failures++; $display("FAIL rand_count_state n=%0d got=%0d/%0d exp=%0d/%0d", n, o_count, o_state, m_count, m_state);
      end
      checks++; if (o_expire !== (m_expire != 0) || o_err !== (m_err != 0)
                    || o_busy !== (m_state == 1 || m_state == 2)) begin
        failures++; $display("FAIL rand_flags n=%0d got=%b%b%b exp=%0d%0d", n, o_expire, o_err, o_busy, m_expire, m_err);
      end
    end
    i_pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_err();
    test_stop_cases();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable interval timer controller that sequences a prescaler counter and a period down-counter, both built from the team's modulo-N counting style.
- Runtime period, one-shot or periodic mode, pause/resume and abort.
- Sits between firmware-style control strobes (buttons, UART command decoder) and consumers of timeouts: blinkers, debounce windows, display refresh, watchdogs.

Parameters:
CLK_DIV, 25000, clock cycles per timer tick (prescaler modulus); legal range >= 1
WIDTH, 16, width of period and remaining-count values

Ports:
i_clk  in  1  system clock, all state changes on rising edge
i_reset  in  1  asynchronous, active-high; clears all state immediately
i_start  in  1  single-cycle strobe: load period, (re)start timer
i_stop  in  1  single-cycle strobe: abort to IDLE
i_pause  in  1  level: hold timer while high
i_periodic  in  1  mode, sampled with i_start: 1=auto-reload, 0=one-shot
i_period  in  WIDTH  ticks per interval, sampled with i_start
o_count  out  WIDTH  ticks remaining in current interval
o_tick  out  1  combinational prescaler tick (RUNNING and prescaler==CLK_DIV-1)
o_expire  out  1  registered one-cycle pulse at interval end
o_err  out  1  registered one-cycle pulse: start rejected (period 0)
o_busy  out  1  high in RUNNING or PAUSED
o_state  out  2  IDLE=0, RUNNING=1, PAUSED=2, DONE=3

Behaviour:
- Reset (async, any time incl. mid-interval): state IDLE, prescaler 0, o_count 0, latched period 0, latched mode 0, o_expire 0, o_err 0. o_busy and o_tick are therefore 0.
- Prescaler counts 0..CLK_DIV-1 and wraps, advancing only in RUNNING with i_pause low.
  - Held in PAUSED.
  - Cleared on any accepted start, on stop and in IDLE/DONE.
  - CLK_DIV=1: prescaler is constant 0, and every running cycle is a tick.
- Control priority each edge: i_stop > i_start > i_pause > tick.
- i_stop in any state:
  - State becomes IDLE, o_count 0, prescaler 0.
  - No o_expire, even if a tick coincides.
- i_start with i_period != 0, in any state:
  - Latch period and mode, o_count <= i_period, prescaler <= 0, state RUNNING.
  - Restarting while RUNNING/PAUSED discards the current interval without an o_expire.
- i_start with i_period == 0:
  - o_err pulses for one cycle.
  - State, count and prescaler are unchanged.
- RUNNING & i_pause high: state becomes PAUSED. The prescaler does not advance that cycle, and no tick occurs.
- PAUSED & i_pause low: state becomes RUNNING. The prescaler resumes from its held value.
- Tick in RUNNING (no stop/start/pause):
  - o_count > 1: o_count decrements.
  - o_count == 1: o_expire <= 1 next cycle.
    - Periodic: o_count <= latched period and state stays RUNNING, with no dead cycle between intervals.
    - One-shot: o_count <= 0 and state becomes DONE.
- DONE holds o_count 0 until i_start or i_stop. i_pause is ignored in DONE and IDLE.
- Latency: if the start is accepted at edge 0 with no pause, the k-th decrement occurs at edge k*CLK_DIV. o_expire is high between edges P*CLK_DIV and P*CLK_DIV+1. Periodic expiries repeat every P*CLK_DIV cycles.
- Width: i_period up to 2^WIDTH-1 is legal, and the count never underflows. Prescaler width is max(1, clog2(CLK_DIV)).

Test Plan:
- CLK_DIV=4, WIDTH=8. Start with period=3, one-shot -> o_count 3,2,1,0 at edges 4,8,12. o_expire is high exactly in the cycle after edge 12. o_state goes 1->3. o_busy drops at edge 12.
- Start with period=2, periodic; run 20 cycles -> o_expire at edges 8 and 16. o_count reloads 2 at each. State stays RUNNING.
- Period=3, periodic; hold i_pause for 5 cycles after edge 5 -> state PAUSED and o_count/prescaler frozen during the pause. Expiry is delayed by exactly 5 cycles, to edge 17.
- Start with period=0 while idle -> o_err one-cycle pulse, state stays IDLE. Start with period=0 while RUNNING -> o_err pulse, and the timer continues its current countdown unaffected.
- Assert i_start and i_stop in the same cycle while running -> IDLE, o_count 0. i_stop in the cycle of the final tick -> no o_expire. Re-start mid-interval -> count reloads, no o_expire.
- Assert i_reset asynchronously mid-interval, between clock edges -> outputs clear before the next edge. After release, the timer stays IDLE until i_start.
